delay_steer_ctrl: RTL
=====================

DELAY_STEER_CTRL -- requirements
Module: delay_steer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_MICS, 16, number of microphone channels
- DELAY_W, 6, per-mic delay width in samples
- DIR_W, 5, steering-direction index width
- MAX_DELAY, 47, largest legal delay (delay line depth minus 1)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, reset; asynchronous, active-high
- dir_valid, in, 1, new steering-direction request
- dir_ready, out, 1, controller can accept a request
- dir_sel, in, DIR_W, requested direction index
- tbl_rd_en, out, 1, delay-table read strobe
- tbl_addr, out, DIR_W+4, table address = {dir, mic}
- tbl_rd_data, in, DELAY_W, table data, valid exactly 1 cycle after tbl_rd_en
- sample_strobe, in, 1, one-cycle pulse per PCM sample period
- mic_delays, out, NUM_MICS*DELAY_W, active delays; mic i at bits [DELAY_W*i+DELAY_W-1 : DELAY_W*i]
- cur_dir, out, DIR_W, direction currently applied
- cfg_applied, out, 1, one-cycle pulse when a new configuration takes effect
- clamp_flag, out, 1, a fetched delay exceeded MAX_DELAY

Function
REQ-003 FSM states: IDLE, FETCH, WAIT_COMMIT.
REQ-004 dir_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with dir_valid=1 and dir_ready=1.
REQ-005 On accept, the controller SHALL latch dir_sel, clear the mic counter, clear clamp_flag, and enter FETCH.
REQ-006 FETCH SHALL assert tbl_rd_en on 16 consecutive cycles, starting the cycle after accept, with tbl_addr = {latched_dir, mic} for mic = 0..15 in order.
REQ-007 tbl_rd_data SHALL be captured into shadow register mic, one cycle after the corresponding read.
REQ-008 If captured data > MAX_DELAY, the controller SHALL store MAX_DELAY and set clamp_flag; clamp_flag holds until the next accept.
REQ-009 The cycle after the last capture (accept at T: reads T+1..T+16, captures T+2..T+17), the FSM SHALL enter WAIT_COMMIT at T+18.
REQ-010 In WAIT_COMMIT, on the first cycle with sample_strobe=1, the controller SHALL copy all shadow delays to mic_delays and the latched direction to cur_dir, both updated atomically at that clock edge.
REQ-011 cfg_applied SHALL be 1 for exactly the cycle after that edge; the FSM returns to IDLE on the same edge.
REQ-012 sample_strobe outside WAIT_COMMIT SHALL be ignored; mic_delays SHALL never change except at the commit edge or on reset.
REQ-013 dir_valid while dir_ready=0 SHALL be ignored and not queued.
REQ-014 Requesting the direction already applied SHALL still run a full fetch/commit.
REQ-015 tbl_rd_en SHALL be 0 outside FETCH, and tbl_addr SHALL hold its last value.

Reset
REQ-016 Asserting rst SHALL force, at any time including mid-FETCH or in WAIT_COMMIT, the following: FSM=IDLE, mic_delays=0, shadow=0, cur_dir=0, cfg_applied=0, clamp_flag=0, tbl_rd_en=0, tbl_addr=0, dir_ready=1 after release.
REQ-017 A fetch interrupted by reset SHALL leave no partial update; the first post-reset request starts from mic 0.

Verification
REQ-018 Table entry (dir d, mic m) = (d+m) mod 48. Accept dir=3 at T -> tbl_addr 0x030..0x03F at T+1..T+16; strobe at T+25 -> mic_delays mic m = 3+m, cur_dir=3, cfg_applied high at T+26 only.
REQ-019 Strobe at T+10 (in FETCH) and at T+18 -> commit occurs at the T+18 edge, not at T+10; mic_delays unchanged before T+19.
REQ-020 Table returns 60 for mic 5 -> mic 5 delay = 47, clamp_flag=1; the next accept clears clamp_flag.
REQ-021 dir_valid held high with dir=7 then 9 during FETCH -> only dir=7 fetched; dir=9 accepted after return to IDLE.
REQ-022 rst pulsed at T+8 of a fetch -> all outputs zero, no cfg_applied; new request completes normally.
REQ-023 Back-to-back requests dir=1 then dir=2 with dir_valid held -> two commits, cur_dir sequence 1 then 2, one cfg_applied pulse each.

Source files
------------

// File: rtl/delay_steer_ctrl.sv
// Beam-steering delay controller.
// A direction request walks the delay table for every microphone, stores the
// results in a shadow bank, and then swaps the whole bank into the active
// delay outputs on the next PCM sample boundary, so the delay set in use is
// never partly old and partly new.
//
// Request handshake: a request transfers on a rising clk edge where
// dir_valid=1 and dir_ready=1. dir_ready is 1 only while idle. A request
// presented while dir_ready=0 is ignored and not remembered.
module delay_steer_ctrl #(
    parameter int NUM_MICS  = 16,
    parameter int DELAY_W   = 6,
    parameter int DIR_W     = 5,
    parameter int MAX_DELAY = 47
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dir_valid,
    output logic                        dir_ready,
    input  logic [DIR_W-1:0]            dir_sel,
    output logic                        tbl_rd_en,
    output logic [DIR_W+3:0]            tbl_addr,
    input  logic [DELAY_W-1:0]          tbl_rd_data,
    input  logic                        sample_strobe,
    output logic [NUM_MICS*DELAY_W-1:0] mic_delays,
    output logic [DIR_W-1:0]            cur_dir,
    output logic                        cfg_applied,
    output logic                        clamp_flag,
    output logic [1:0]                  dbg_state
);

    // The mic index occupies the low four address bits.
    localparam int MIC_W = 4;
    localparam logic [MIC_W-1:0]   LAST_MIC = MIC_W'(NUM_MICS - 1);
    localparam logic [DELAY_W-1:0] MAX_D    = DELAY_W'(MAX_DELAY);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FETCH       = 2'd1,
        WAIT_COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;

    // Request latched at accept; drives the table address and cur_dir on commit.
    logic [DIR_W-1:0]     dir_q;
    // Read sequencer: strobe and mic index of the read being issued.
    logic                 rd_en_q;
    logic [MIC_W-1:0]     rd_mic_q;
    // Capture pipeline: marks the cycle the table data for cap_mic_q is valid.
    logic                 cap_valid_q;
    logic [MIC_W-1:0]     cap_mic_q;
    // Shadow bank filled during the fetch.
    logic [DELAY_W-1:0]   shadow_q [NUM_MICS];
    logic [NUM_MICS*DELAY_W-1:0] shadow_flat;
    // Applied configuration.
    logic [NUM_MICS*DELAY_W-1:0] mic_delays_q;
    logic [DIR_W-1:0]     cur_dir_q;
    logic                 cfg_applied_q;
    logic                 clamp_q;

    logic                 accept;
    logic                 last_capture;
    logic                 commit;
    logic                 over_max;

    assign accept       = (state_q == IDLE) && dir_valid;
    assign last_capture = cap_valid_q && (cap_mic_q == LAST_MIC);
    assign commit       = (state_q == WAIT_COMMIT) && sample_strobe;
    assign over_max     = tbl_rd_data > MAX_D;

    assign dir_ready   = (state_q == IDLE);
    assign tbl_rd_en   = rd_en_q;
    assign tbl_addr    = {dir_q, rd_mic_q};
    assign mic_delays  = mic_delays_q;
    assign cur_dir     = cur_dir_q;
    assign cfg_applied = cfg_applied_q;
    assign clamp_flag  = clamp_q;
    assign dbg_state   = state_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fetch ends after the last mic is captured, commit waits for a sample strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (last_capture) begin
                    state_d = WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                if (sample_strobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read sequencer: one table read per cycle for mic 0..NUM_MICS-1 after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q    <= '0;
            rd_en_q  <= 1'b0;
            rd_mic_q <= '0;
        end else if (accept) begin
            dir_q    <= dir_sel;
            rd_en_q  <= 1'b1;
            rd_mic_q <= '0;
        end else if (rd_en_q) begin
            if (rd_mic_q == LAST_MIC) begin
                rd_en_q <= 1'b0;
            end else begin
                rd_mic_q <= rd_mic_q + 4'd1;
            end
        end
    end

    // Capture pipeline: table data arrives one cycle after its read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_mic_q   <= '0;
        end else begin
            cap_valid_q <= rd_en_q;
            cap_mic_q   <= rd_mic_q;
        end
    end

    // Shadow bank: store each fetched delay, saturating anything beyond the delay line depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MICS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (cap_valid_q) begin
            shadow_q[cap_mic_q] <= over_max ? MAX_D : tbl_rd_data;
        end
    end

    // Clamp indicator: cleared by a new request, set by any saturated capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_q <= 1'b0;
        end else if (accept) begin
            clamp_q <= 1'b0;
        end else if (cap_valid_q && over_max) begin
            clamp_q <= 1'b1;
        end
    end

    // Flatten the shadow bank into the output bit layout.
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < NUM_MICS; i++) begin
            shadow_flat[DELAY_W*i +: DELAY_W] = shadow_q[i];
        end
    end

    // Commit: swap the whole shadow bank and direction in on a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mic_delays_q  <= '0;
            cur_dir_q     <= '0;
            cfg_applied_q <= 1'b0;
        end else begin
            cfg_applied_q <= commit;
            if (commit) begin
                mic_delays_q <= shadow_flat;
                cur_dir_q    <= dir_q;
            end
        end
    end

endmodule
